// File: rtl/operand_reader.sv
// Operand read stage: 16-entry register file, busy-bit scoreboard and a
// one-deep registered response with a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | no response held, resp_valid = 0
// FULL  | op1/op2 hold a response waiting for resp_ready
module operand_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic                set_busy,
  input  logic [ADDR_W-1:0]   rd_dest,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   op1,
  output logic [DATA_W-1:0]   op2,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     busy_q, busy_d;
  logic [DATA_W-1:0]       op1_q, op1_d;
  logic [DATA_W-1:0]       op2_q, op2_d;

  logic wb_hit1, wb_hit2;
  logic haz_1, haz_2, hazard;
  logic accept;

  // A writeback landing this cycle resolves the hazard and is forwarded.
  always_comb begin
    wb_hit1 = wb_en && (wb_addr == rs1);
    wb_hit2 = wb_en && (wb_addr == rs2);
    haz_1   = use_rs1 && busy_q[rs1] && !wb_hit1;
    haz_2   = use_rs2 && busy_q[rs2] && !wb_hit2;
    hazard  = haz_1 || haz_2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (resp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = !hazard && ((state_q == EMPTY) || resp_ready);
    resp_valid = (state_q == FULL);
    op1        = op1_q;
    op2        = op2_q;
    busy_vec   = busy_q;
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    if (accept) begin
      op1_d = wb_hit1 ? wb_data : regs_q[rs1];
      op2_d = wb_hit2 ? wb_data : regs_q[rs2];
    end
  end

  // Set is applied after clear so a same-index reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)             busy_d[wb_addr] = 1'b0;
    if (accept && set_busy) busy_d[rd_dest] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_operand_reader.sv
// Directed bench for operand_reader: per-cycle vector table plus a register
// walk and a bounded stall/bypass sequence.
module tb_operand_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  rs1, rs2, rd_dest, wb_addr;
  logic        use_rs1, use_rs2, set_busy;
  logic        resp_valid, resp_ready;
  logic [31:0] op1, op2, wb_data;
  logic        wb_en;
  logic [15:0] busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .set_busy(set_busy), .rd_dest(rd_dest),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .op1(op1), .op2(op2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec)
  );

  typedef struct {
    logic        rst, rv, u1, u2, sb, rr, wb;
    logic [3:0]  rs1, rs2, rd, wa;
    logic [31:0] wd;
    logic        chk_rdy, e_rdy, e_rv;
    logic [31:0] e_op1, e_op2;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic v, input logic [3:0] a1, input logic u1,
    input logic [3:0] a2, input logic u2, input logic sb, input logic [3:0] rd,
    input logic rr, input logic wb, input logic [3:0] wa, input logic [31:0] wd,
    input logic crdy, input logic erdy, input logic erv,
    input logic [31:0] eo1, input logic [31:0] eo2, input logic [15:0] eb);
    vec_t t;
    t.rst = r;  t.rv = v;  t.rs1 = a1; t.u1 = u1; t.rs2 = a2; t.u2 = u2;
    t.sb = sb;  t.rd = rd; t.rr = rr;  t.wb = wb; t.wa = wa;  t.wd = wd;
    t.chk_rdy = crdy; t.e_rdy = erdy; t.e_rv = erv;
    t.e_op1 = eo1; t.e_op2 = eo2; t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; req_valid = t.rv; rs1 = t.rs1; use_rs1 = t.u1;
    rs2 = t.rs2; use_rs2 = t.u2; set_busy = t.sb; rd_dest = t.rd;
    resp_ready = t.rr; wb_en = t.wb; wb_addr = t.wa; wb_data = t.wd;
  endtask

  task automatic idle();
    drive(mk(0,0, 0,0,0,0, 0,0, 1, 0,0,0, 0,0, 0,0,0,0));
  endtask

  initial begin
    // rst rv rs1 u1 rs2 u2 sb rd rr wb wa wd | chk e_rdy e_rv e_op1 e_op2 e_busy
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0, 0, 0,0,0,             0,0, 0,0,0,16'h0000));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0, 1,3,32'h000000A5,  1,1, 0,0,0,16'h0000));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0, 1,7,32'hDEADBEEF,  1,1, 0,0,0,16'h0000));
    vecs.push_back(mk(0,1, 3,1,7,1, 0,0, 1, 0,0,0,             1,1, 1,32'hA5,32'hDEADBEEF,16'h0000));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,5, 1, 0,0,0,             1,1, 1,0,0,16'h0020));
    vecs.push_back(mk(0,1, 5,1,0,0, 0,0, 1, 0,0,0,             1,0, 0,0,0,16'h0020));
    vecs.push_back(mk(0,1, 5,1,0,0, 0,0, 1, 0,0,0,             1,0, 0,0,0,16'h0020));
    vecs.push_back(mk(0,1, 5,1,0,0, 0,0, 1, 1,5,32'h1234,      1,1, 1,32'h1234,0,16'h0000));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,5, 1, 0,0,0,             1,1, 1,0,0,16'h0020));
    vecs.push_back(mk(0,1, 5,0,3,1, 0,0, 1, 0,0,0,             1,1, 1,32'h1234,32'hA5,16'h0020));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 1, 1,5,32'h5555,      1,1, 0,32'h1234,32'hA5,16'h0000));
    vecs.push_back(mk(0,1, 7,1,3,1, 0,0, 0, 0,0,0,             1,1, 1,32'hDEADBEEF,32'hA5,16'h0000));
    vecs.push_back(mk(0,1, 7,1,3,1, 0,0, 0, 1,7,32'h77,        1,0, 1,32'hDEADBEEF,32'hA5,16'h0000));
    vecs.push_back(mk(0,1, 7,1,3,1, 0,0, 1, 0,0,0,             1,1, 1,32'h77,32'hA5,16'h0000));
    vecs.push_back(mk(0,1, 3,1,5,1, 0,0, 1, 0,0,0,             1,1, 1,32'hA5,32'h5555,16'h0000));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,9, 1, 1,9,32'h55,        1,1, 1,0,0,16'h0200));
    vecs.push_back(mk(0,1, 9,0,9,0, 0,0, 1, 0,0,0,             1,1, 1,32'h55,32'h55,16'h0200));
    vecs.push_back(mk(0,1, 9,1,0,0, 0,0, 1, 0,0,0,             1,0, 0,32'h55,32'h55,16'h0200));
    vecs.push_back(mk(0,1, 9,1,0,0, 0,0, 1, 1,9,32'h99,        1,1, 1,32'h99,0,16'h0000));
    vecs.push_back(mk(0,1, 3,1,7,1, 1,3, 1, 0,0,0,             1,1, 1,32'hA5,32'h77,16'h0008));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,4, 1, 1,3,32'h33,        1,1, 1,0,0,16'h0010));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,5, 1, 0,0,0,             1,1, 1,0,0,16'h0030));
    vecs.push_back(mk(0,1, 0,0,0,0, 1,6, 1, 0,0,0,             1,1, 1,0,0,16'h0070));
    vecs.push_back(mk(0,1, 7,0,3,0, 1,7, 1, 0,0,0,             1,1, 1,32'h77,32'h33,16'h00F0));
    vecs.push_back(mk(1,1, 0,0,0,0, 1,2, 0, 1,1,32'hFFFF,      0,0, 0,0,0,16'h0000));
    vecs.push_back(mk(0,1, 3,0,7,0, 0,0, 1, 0,0,0,             1,1, 1,0,0,16'h0000));
    vecs.push_back(mk(0,1, 1,0,9,0, 0,0, 1, 0,0,0,             1,1, 1,0,0,16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      if (vecs[i].chk_rdy) chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d op1", i), op1, vecs[i].e_op1);
      chk($sformatf("v%0d op2", i), op2, vecs[i].e_op2);
      chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vecs[i].e_busy));
    end

    // Register walk: every index, including 15, must store and read back.
    for (int i = 0; i < 16; i++) begin
      idle(); wb_en = 1'b1; wb_addr = 4'(i); wb_data = 32'h100 + 32'(i * 3);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) begin
      idle(); req_valid = 1'b1; rs1 = 4'(i); rs2 = 4'(15 - i);
      use_rs1 = 1'b1; use_rs2 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("walk r%0d op1", i), op1, 32'h100 + 32'(i * 3));
      chk($sformatf("walk r%0d op2", i), op2, 32'h100 + 32'((15 - i) * 3));
    end

    // Stall on a reserved source until a writeback arrives, with a cycle budget.
    idle(); req_valid = 1'b1; set_busy = 1'b1; rd_dest = 4'd12;
    @(posedge clk); #1;
    chk("stall busy12", 32'(busy_vec), 32'h1000);
    begin
      bit got = 1'b0;
      for (int cyc = 0; cyc < 8 && !got; cyc++) begin
        idle(); req_valid = 1'b1; rs1 = 4'd12; use_rs1 = 1'b1;
        wb_en = (cyc == 3); wb_addr = 4'd12; wb_data = 32'hCAFE_0012;
        #2;
        chk($sformatf("stall cyc%0d req_ready", cyc), 32'(req_ready), 32'(cyc == 3));
        got = req_ready;
        @(posedge clk); #1;
      end
      chk("stall accepted", 32'(got), 32'h1);
      chk("stall bypass op1", op1, 32'hCAFE_0012);
      chk("stall busy clear", 32'(busy_vec), 32'h0);
      chk("stall resp_valid", 32'(resp_valid), 32'h1);
    end

    idle();
    @(posedge clk); #1;
    chk("drain resp_valid", 32'(resp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
